// File: rtl/led_status_ctrl.sv
// led_status_ctrl: heartbeat, PLL-lock and blink-code status LEDs with PWM brightness.
// All LED outputs are active-low and registered; sequencing is driven by a 1 ms tick.
module led_status_ctrl #(
   parameter int TICK_DIV = 27000,
   parameter int HB_MS    = 500,
   parameter int ON_MS    = 200,
   parameter int OFF_MS   = 200,
   parameter int GAP_MS   = 1000
) (
   input  logic       clk_27m,
   input  logic       rst,
   input  logic       pll_lock,
   input  logic       err_valid,
   input  logic [3:0] err_code,
   input  logic [7:0] brightness,
   output logic [5:0] led,
   output logic       busy
);
   localparam int PW   = $clog2(TICK_DIV) > 0 ? $clog2(TICK_DIV) : 1;
   localparam int HW   = $clog2(HB_MS + 1);
   localparam int DMAX = ON_MS > OFF_MS ? (ON_MS > GAP_MS ? ON_MS : GAP_MS)
                                        : (OFF_MS > GAP_MS ? OFF_MS : GAP_MS);
   localparam int DW   = $clog2(DMAX + 1);

   typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

   state_t          state, state_n;
   logic [3:0]      rem, rem_n;
   logic [DW-1:0]   dur, dur_n, lim;
   logic [PW-1:0]   presc;
   logic [HW-1:0]   hb_cnt;
   logic [7:0]      pwm_cnt, bright_q;
   logic            lock_m, lock_s, lock_lost, hb, tick, pwm_on, done;

   assign tick   = presc == PW'(TICK_DIV - 1);
   assign pwm_on = pwm_cnt < bright_q;
   assign busy   = state != IDLE;

   always_comb begin
      lim     = state == ON ? DW'(ON_MS - 1) : state == OFF ? DW'(OFF_MS - 1) : DW'(GAP_MS - 1);
      done    = tick && dur == lim;
      state_n = state;
      rem_n   = rem;
      if (state == IDLE) begin
         if (err_valid && err_code != 4'd0) begin
            state_n = ON;
            rem_n   = err_code;
         end
      end else if (done) begin
         if (state == ON) begin
            rem_n   = rem - 4'd1;
            state_n = rem == 4'd1 ? GAP : OFF;
         end else begin
            state_n = state == OFF ? ON : IDLE;
         end
      end
      dur_n = state_n != state ? '0 : (tick && state != IDLE) ? dur + 1'b1 : dur;
   end

   always_ff @(posedge clk_27m or posedge rst) begin
      if (rst) begin
         lock_m    <= 1'b0;
         lock_s    <= 1'b0;
         lock_lost <= 1'b0;
         presc     <= '0;
         hb_cnt    <= '0;
         hb        <= 1'b0;
         pwm_cnt   <= 8'd0;
         bright_q  <= 8'd0;
         state     <= IDLE;
         rem       <= 4'd0;
         dur       <= '0;
         led       <= 6'h3F;
      end else begin
         lock_m    <= pll_lock;
         lock_s    <= lock_m;
         // lock_s is about to fall: flag it on the same edge lock_s goes low
         lock_lost <= lock_lost | (lock_s & ~lock_m);
         presc     <= tick ? '0 : presc + 1'b1;
         if (tick) begin
            hb_cnt <= hb_cnt == HW'(HB_MS - 1) ? '0 : hb_cnt + 1'b1;
            if (hb_cnt == HW'(HB_MS - 1))
               hb <= ~hb;
         end
         pwm_cnt   <= pwm_cnt + 8'd1;
         if (pwm_cnt == 8'hFF)
            bright_q <= brightness;
         state     <= state_n;
         rem       <= rem_n;
         dur       <= dur_n;
         led       <= {1'b1, ~(lock_lost & pwm_on), ~(busy & pwm_on), ~((state == ON) & pwm_on),
                       ~(lock_s & pwm_on), ~(hb & pwm_on)};
      end
   end
endmodule

// File: doc/led_status_ctrl.md
LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 27000, giving clk_27m cycles per ms tick (27 MHz -> 1 kHz).
REQ-002 SHALL have parameter HB_MS, default 500, giving the heartbeat half-period in ticks.
REQ-003 SHALL have parameters ON_MS=200, OFF_MS=200 and GAP_MS=1000, giving blink-code ON, OFF and post-code GAP durations in ticks.
REQ-004 SHALL have port clk_27m, input, 1 bit: the single clock, 27 MHz.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port pll_lock, input, 1 bit: PLL lock status, asynchronous to clk_27m.
REQ-007 SHALL have port err_valid, input, 1 bit: single-cycle request to display err_code.
REQ-008 SHALL have port err_code, input, 4 bits: error number; 0 means no error.
REQ-009 SHALL have port brightness, input, 8 bits: PWM duty for all lit LEDs.
REQ-010 SHALL have port led, output, 6 bits: active-low LED drive (0 = lit).
REQ-011 SHALL have port busy, output, 1 bit: blink-code sequence in progress.

Function
REQ-012 SHALL synchronise pll_lock through 2 flops, giving lock_s; all logic uses lock_s only.
REQ-013 SHALL pulse tick for exactly one cycle every TICK_DIV cycles, using a prescaler that counts 0..TICK_DIV-1 and wraps.
REQ-014 SHALL toggle hb every HB_MS ticks, using a tick counter that clears at each toggle.
REQ-015 SHALL increment an 8-bit pwm_cnt every cycle, wrapping from 255 to 0.
REQ-016 SHALL load brightness into bright_q only in the cycle pwm_cnt==255, so duty never changes mid-period.
REQ-017 SHALL define pwm_on = (pwm_cnt < bright_q); bright_q=0 gives always off, and 255 gives 255 of 256 cycles on.
REQ-018 SHALL set sticky flag lock_lost on a 1->0 transition of lock_s; only rst clears it.
REQ-019 SHALL implement blink FSM states IDLE, ON, OFF and GAP, with a tick-duration counter and a 4-bit remaining-count register.
REQ-020 SHALL, in IDLE with err_valid=1 and err_code!=0, latch remaining=err_code, clear the duration counter and enter ON next cycle.
REQ-021 SHALL, in ON after ON_MS ticks, decrement remaining; if the new value is 0 enter GAP, else enter OFF; the duration counter clears on every state change.
REQ-022 SHALL, in OFF after OFF_MS ticks, return to ON.
REQ-023 SHALL, in GAP after GAP_MS ticks, return to IDLE.
REQ-024 SHALL ignore err_valid outside IDLE (no queueing) and ignore err_code=0 in all states.
REQ-025 SHALL hold busy=1 in ON, OFF and GAP, and busy=0 in IDLE.
REQ-026 SHALL register led, 1-cycle latency, with mapping:
- led[0]=~(hb & pwm_on)
- led[1]=~(lock_s & pwm_on)
- led[2]=~(state==ON & pwm_on)
- led[3]=~(busy & pwm_on)
- led[4]=~(lock_lost & pwm_on)
- led[5]=1
REQ-027 SHALL give the first ON phase a duration between ON_MS-1 and ON_MS ticks, because the prescaler is free-running; all later phases are exact.

Reset
REQ-028 SHALL, while rst=1 (asynchronously), force:
- led=6'h3F and busy=0
- state=IDLE, remaining=0
- all counters 0, hb=0, bright_q=0
- lock sync flops 0, lock_lost=0
REQ-029 SHALL, after rst deasserts, keep all LEDs off until the first pwm_cnt wrap loads bright_q (256 cycles).
REQ-030 SHALL, on rst asserted mid-sequence, abandon the sequence; behaviour after release is as from power-up.

Verification
Parameters for all scenarios: TICK_DIV=4, HB_MS=5, ON_MS=2, OFF_MS=2, GAP_MS=3.
REQ-031 SHALL cover reset: rst=1 with pll_lock=1, brightness=255 -> led=6'h3F and busy=0 immediately; after release, led[1] stays 1 until 256 cycles elapse, then goes low within 1 cycle of the first PWM slot.
REQ-032 SHALL cover PWM duty: brightness=64, pll_lock=1 steady -> led[1]=0 for exactly 64 of every 256 cycles, and a brightness change mid-period takes effect only at the next wrap.
REQ-033 SHALL cover blink code: err_valid pulse with err_code=3, brightness=255 -> led[2] shows exactly 3 lit bursts; busy=1 from the next cycle until 3 GAP ticks after the 3rd ON ends, then 0.
REQ-034 SHALL cover ignored requests: err_valid with err_code=5 during an active sequence, and err_valid with err_code=0 in IDLE -> no change to the sequence or busy.
REQ-035 SHALL cover lock loss: pll_lock 1->0->1 -> led[4] lit (PWM-gated) 3 cycles after the fall and stays lit after lock returns, until rst.
REQ-036 SHALL cover reset mid-blink: rst pulse during OFF with remaining=2 -> led=6'h3F and busy=0 asynchronously, then state=IDLE after release.
